// File: rtl/flash_xip_cache_if.sv
// APB bus bundle shared by the upstream (CPU) and downstream (SPI controller)
// sides of flash_xip_cache.
//   master modport: drives paddr/psel/penable/pprot/pwrite/pwdata/pstrb,
//                   receives pready/prdata/pslverr
//   slave modport : the mirror image
interface flash_xip_cache_if;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic [2:0]  pprot;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  modport master (
    output paddr, psel, penable, pprot, pwrite, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pprot, pwrite, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/flash_xip_cache.sv
// Direct-mapped, one-word-per-line read cache in front of the SPI flash APB
// controller. Flash-window read hits answer with zero wait states; misses and
// all non-flash transfers are forwarded downstream; flash writes get an error.
// Ports:
//   clock, reset - system clock, synchronous active-high reset
//   flush        - one-cycle pulse invalidating every line
//   cpu          - upstream APB (slave side)
//   spi          - downstream APB to the SPI controller (master side)
module flash_xip_cache #(
  parameter logic [31:0] flash_addr_start = 32'h3000_0000,
  parameter logic [31:0] flash_addr_end   = 32'h3fff_ffff,
  parameter int unsigned idx_bits         = 4,
  parameter int unsigned tag_bits         = 22 - idx_bits
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  flash_xip_cache_if.slave   cpu,
  flash_xip_cache_if.master  spi
);

  localparam int unsigned lines = 1 << idx_bits;

  typedef enum logic [2:0] {
    IDLE, HIT, ERR, DN_SETUP, DN_ACCESS, RESP
  } state_t;

  state_t state_q, state_d;

  // Cache storage
  logic [lines-1:0]    valid_q;
  logic [tag_bits-1:0] tag_q  [lines];
  logic [31:0]         data_q [lines];

  // Captured lookup context for the line fill
  logic                fill_q;
  logic [idx_bits-1:0] cap_idx_q;
  logic [tag_bits-1:0] cap_tag_q;

  // Registered outputs
  logic        pready_q, pslverr_q;
  logic [31:0] prdata_q;
  logic [31:0] paddr_q, pwdata_q;
  logic        psel_q, penable_q, pwrite_q;
  logic [2:0]  pprot_q;
  logic [3:0]  pstrb_q;

  // Next-cycle control
  logic        pready_d, pslverr_d;
  logic [31:0] prdata_d;
  logic        cap_en, fill_en;

  // Lookup on the live upstream address
  logic                setup_c, is_flash_c, hit_c;
  logic [idx_bits-1:0] idx_c;
  logic [tag_bits-1:0] tag_c;

  assign setup_c    = cpu.psel && !cpu.penable;
  assign is_flash_c = (cpu.paddr >= flash_addr_start) && (cpu.paddr <= flash_addr_end);
  assign idx_c      = cpu.paddr[2+idx_bits-1:2];
  assign tag_c      = cpu.paddr[23:2+idx_bits];
  // A flush in the lookup cycle counts as already applied
  assign hit_c      = !flush && valid_q[idx_c] && (tag_q[idx_c] == tag_c);

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    cap_en    = 1'b0;
    fill_en   = 1'b0;
    pready_d  = 1'b0;
    prdata_d  = 32'h0;
    pslverr_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (setup_c) begin
          cap_en = 1'b1;
          if (is_flash_c && !cpu.pwrite && hit_c) begin
            state_d  = HIT;
            pready_d = 1'b1;
            prdata_d = data_q[idx_c];
          end else if (is_flash_c && cpu.pwrite) begin
            state_d   = ERR;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
          end else begin
            state_d = DN_SETUP;
          end
        end
      end
      HIT, ERR, RESP: state_d = IDLE;
      DN_SETUP:       state_d = DN_ACCESS;
      DN_ACCESS: begin
        if (spi.pready) begin
          state_d   = RESP;
          pready_d  = 1'b1;
          prdata_d  = spi.prdata;
          pslverr_d = spi.pslverr;
          fill_en   = fill_q && !spi.pslverr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, capture and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      fill_q    <= 1'b0;
      cap_idx_q <= '0;
      cap_tag_q <= '0;
      pready_q  <= 1'b0;
      prdata_q  <= 32'h0;
      pslverr_q <= 1'b0;
      paddr_q   <= 32'h0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pprot_q   <= 3'h0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= 32'h0;
      pstrb_q   <= 4'h0;
    end else begin
      state_q   <= state_d;
      pready_q  <= pready_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
      psel_q    <= (state_d == DN_SETUP) || (state_d == DN_ACCESS);
      penable_q <= (state_d == DN_ACCESS);
      if (cap_en) begin
        fill_q    <= is_flash_c && !cpu.pwrite;
        cap_idx_q <= idx_c;
        cap_tag_q <= tag_c;
      end
      // Downstream fields load once per forwarded transfer and hold after it
      if (cap_en && (state_d == DN_SETUP)) begin
        paddr_q  <= cpu.paddr;
        pprot_q  <= cpu.pprot;
        pwrite_q <= cpu.pwrite;
        pwdata_q <= cpu.pwdata;
        pstrb_q  <= cpu.pstrb;
      end
    end
  end

  // Valid bits: flush wins over a coincident fill
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[cap_idx_q] <= 1'b1;
    end
  end

  // Line payload; only meaningful where valid is set
  always_ff @(posedge clock) begin
    if (fill_en) begin
      tag_q[cap_idx_q]  <= cap_tag_q;
      data_q[cap_idx_q] <= spi.prdata;
    end
  end

  assign cpu.pready  = pready_q;
  assign cpu.prdata  = prdata_q;
  assign cpu.pslverr = pslverr_q;
  assign spi.paddr   = paddr_q;
  assign spi.psel    = psel_q;
  assign spi.penable = penable_q;
  assign spi.pprot   = pprot_q;
  assign spi.pwrite  = pwrite_q;
  assign spi.pwdata  = pwdata_q;
  assign spi.pstrb   = pstrb_q;

endmodule
